// File: rtl/weight_sched_if.sv
// weight_sched_if: start/FC handshake, ROM read port and weight outputs of weight_sched.
interface weight_sched_if #(
  parameter int FC_UNITS = 10,
  parameter int AW       = 8
);
  logic                start;
  logic                fc_ivalid;
  logic [FC_UNITS-1:0] rom_data;
  logic                rom_rd;
  logic [AW-1:0]       rom_addr;
  logic                weight_conv;
  logic                weight_en_0;
  logic                weight_en_1;
  logic [FC_UNITS-1:0] weight_fc;
  logic                fc_ready;
  logic                busy;
  logic                done;
  logic                underflow;
  modport master (
    output start, fc_ivalid, rom_data,
    input  rom_rd, rom_addr, weight_conv, weight_en_0, weight_en_1, weight_fc,
           fc_ready, busy, done, underflow
  );
  modport slave (
    input  start, fc_ivalid, rom_data,
    output rom_rd, rom_addr, weight_conv, weight_en_0, weight_en_1, weight_fc,
           fc_ready, busy, done, underflow
  );
endinterface

// File: rtl/weight_sched.sv
// weight_sched: streams conv0/conv1 kernels serially, then feeds FC words through a 2-entry prefetch FIFO.
module weight_sched #(
  parameter int CONV_WEIGHTS = 9,
  parameter int FC_INPUTS    = 144,
  parameter int FC_UNITS     = 10,
  parameter int AW           = 8
) (
  input logic           clk,
  input logic           rstn,
  weight_sched_if.slave bus
);
  localparam int FC_BASE = 2 * CONV_WEIGHTS;
  localparam int FC_END  = FC_BASE + FC_INPUTS;
  localparam int PW      = $clog2(FC_INPUTS + 1);
  typedef logic [AW:0] addr_t;
  typedef enum logic [1:0] {IDLE, LOAD_C0, LOAD_C1, FC} state_t;
  state_t              state_q;
  addr_t               nxt_q;
  logic [AW-1:0]       last_q;
  logic [FC_UNITS-1:0] e0_q, e1_q;
  logic [1:0]          cnt_q;
  logic [PW-1:0]       pop_n_q;
  logic                infl_q, en0_q, en1_q, done_q, ready_q, uflow_q;
  logic                in_fc, pop, push, rd, last_pop, ready_d;
  logic [1:0]          cnt_p, cnt_d;
  logic [PW-1:0]       pop_n_d;
  assign in_fc    = state_q == FC;
  assign pop      = in_fc && bus.fc_ivalid && cnt_q != 2'd0;
  assign push     = infl_q;
  // a read is only issued if its word is guaranteed a FIFO slot when it lands
  assign rd       = state_q == LOAD_C0 || state_q == LOAD_C1 ||
                    (in_fc && nxt_q < addr_t'(FC_END) &&
                     {1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop} < 3'd2);
  assign cnt_p    = cnt_q - {1'b0, pop};
  assign cnt_d    = cnt_p + {1'b0, push};
  assign pop_n_d  = pop_n_q + PW'(pop);
  assign last_pop = pop && pop_n_d == PW'(FC_INPUTS);
  assign ready_d  = ready_q || cnt_d == 2'd2 || PW'(cnt_d) == PW'(FC_INPUTS) - pop_n_d;
  assign bus.rom_rd      = rd;
  assign bus.rom_addr    = rd ? nxt_q[AW-1:0] : last_q;
  assign bus.weight_en_0 = en0_q;
  assign bus.weight_en_1 = en1_q;
  assign bus.weight_conv = (en0_q | en1_q) & bus.rom_data[0];
  assign bus.weight_fc   = cnt_q != 2'd0 ? e0_q : '0;
  assign bus.fc_ready    = ready_q;
  assign bus.busy        = state_q != IDLE;
  assign bus.done        = done_q;
  assign bus.underflow   = uflow_q;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      nxt_q   <= '0;
      last_q  <= '0;
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= '0;
      pop_n_q <= '0;
      infl_q  <= 1'b0;
      en0_q   <= 1'b0;
      en1_q   <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      en0_q   <= state_q == LOAD_C0;
      en1_q   <= state_q == LOAD_C1;
      infl_q  <= rd && in_fc;
      done_q  <= 1'b0;
      e0_q    <= push && cnt_p == 2'd0 ? bus.rom_data : pop ? e1_q : e0_q;
      e1_q    <= push && cnt_p == 2'd1 ? bus.rom_data : e1_q;
      cnt_q   <= cnt_d;
      pop_n_q <= pop_n_d;
      if (rd) begin
        last_q <= nxt_q[AW-1:0];
        nxt_q  <= nxt_q + addr_t'(1);
      end
      if (in_fc && bus.fc_ivalid && cnt_q == 2'd0) uflow_q <= 1'b1;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= LOAD_C0;
          nxt_q   <= '0;
          pop_n_q <= '0;
          uflow_q <= 1'b0;
        end
        LOAD_C0: if (nxt_q == addr_t'(CONV_WEIGHTS - 1)) state_q <= LOAD_C1;
        LOAD_C1: if (nxt_q == addr_t'(FC_BASE - 1)) state_q <= FC;
        default: begin
          ready_q <= ready_d && !last_pop;
          if (last_pop) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
      endcase
    end
endmodule

// File: tb/tb_weight_sched.sv
// tb_weight_sched: random and directed stimulus against a queue-based model of the weight schedule.
module tb_weight_sched;
  localparam int CW = 9, FC_BASE = 18, FC_IN = 144, FC_END = 162;
  logic clk = 1'b0, rstn;
  int cyc = 0, mode = 0, lit_sel = 0, n_chk = 0, n_err = 0;
  logic [9:0] rom [256];
  weight_sched_if #(.FC_UNITS(10), .AW(8)) bus ();
  weight_sched #(.CONV_WEIGHTS(CW), .FC_INPUTS(FC_IN), .FC_UNITS(10), .AW(8)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.rom_rd) bus.rom_data <= rom[bus.rom_addr];
  always @(posedge clk) begin
    #1;
    bus.fc_ivalid = mode == 1 ? bus.fc_ready : mode == 2 ? bus.fc_ready && cyc % 2 == 1 :
                    mode == 3 ? $urandom_range(0, 2) != 0 : mode == 4;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask
  // reference model: phase 0 idle, 1 conv loading, 2 FC; FIFO kept as a queue of words
  int m_ph, m_next, m_last, m_infl, m_iaddr, m_prd, m_paddr, m_popped, m_uf, m_rdy, m_done, s_cyc;
  logic [9:0] q[$];
  int t_addr [256];
  int t_en0, t_en1, t_rdy, f_pops;
  logic [8:0] c0, c1;
  logic [9:0] f_first, f_last;
  always @(negedge clk) begin
    int rel;
    logic e_rd, pop, e0, e1, idle;
    if (!rstn) begin
      chk("reset_outputs", {bus.rom_rd, bus.rom_addr, bus.weight_conv, bus.weight_en_0, bus.weight_en_1,
                            bus.weight_fc, bus.fc_ready, bus.busy, bus.done, bus.underflow}, 0);
      m_ph = 0; m_next = 0; m_last = 0; m_infl = 0; m_iaddr = 0; m_prd = 0; m_paddr = 0;
      m_popped = 0; m_uf = 0; m_rdy = 0; m_done = 0; s_cyc = cyc;
      q.delete();
    end else begin
      rel  = cyc - s_cyc;
      pop  = m_ph == 2 && bus.fc_ivalid && q.size() > 0;
      e_rd = m_ph == 1 || (m_ph == 2 && m_next < FC_END && q.size() + m_infl - int'(pop) < 2);
      e0   = m_prd != 0 && m_paddr < CW;
      e1   = m_prd != 0 && m_paddr >= CW;
      chk("rom_rd", bus.rom_rd, e_rd);
      chk("rom_addr", bus.rom_addr, e_rd ? m_next : m_last);
      chk("weight_en_0", bus.weight_en_0, e0);
      chk("weight_en_1", bus.weight_en_1, e1);
      chk("weight_conv", bus.weight_conv, (e0 || e1) ? rom[m_paddr][0] : 1'b0);
      chk("weight_fc", bus.weight_fc, q.size() > 0 ? q[0] : 10'd0);
      chk("fc_ready", bus.fc_ready, m_rdy);
      chk("busy", bus.busy, m_ph != 0);
      chk("done", bus.done, m_done);
      chk("underflow", bus.underflow, m_uf);
      if (bus.rom_rd) t_addr[bus.rom_addr] = rel;
      if (bus.weight_en_0) begin c0 = {c0[7:0], bus.weight_conv}; if (t_en0 < 0) t_en0 = rel; end
      if (bus.weight_en_1) begin c1 = {c1[7:0], bus.weight_conv}; if (t_en1 < 0) t_en1 = rel; end
      if (bus.fc_ready && t_rdy < 0) t_rdy = rel;
      if (pop) begin
        if (f_pops == 0) f_first = bus.weight_fc;
        f_last = bus.weight_fc;
        f_pops++;
      end
      if (lit_sel == 3 && rel == 20) chk("underflow_set", bus.underflow, 1);
      if (lit_sel == 4 && rel == 1) begin
        chk("restart_rd", bus.rom_rd, 1);
        chk("restart_addr", bus.rom_addr, 0);
      end
      if (bus.done && lit_sel == 1) begin
        chk("first_read_cycle", t_addr[0], 1);
        chk("last_conv_read_cycle", t_addr[17], 18);
        chk("first_en0_cycle", t_en0, 2);
        chk("first_en1_cycle", t_en1, 11);
        chk("conv0_bits", c0, 9'b101101100);
        chk("conv1_bits", c1, 9'b011011010);
        chk("first_ready_cycle", t_rdy, 22);
        chk("done_cycle", rel, 166);
      end
      if (bus.done && lit_sel inside {1, 2, 3}) begin
        chk("fc_first_word", f_first, 0);
        chk("fc_last_word", f_last, 143);
        chk("fc_pop_count", f_pops, 144);
        chk("underflow_at_done", bus.underflow, lit_sel == 3);
      end
      if (bus.done && lit_sel == 2) chk("busy_start_ignored", t_addr[17], 18);
      idle = m_ph == 0;
      m_done = 0;
      if (m_ph == 2 && bus.fc_ivalid && q.size() == 0) m_uf = 1;
      if (pop) begin void'(q.pop_front()); m_popped++; end
      if (m_infl != 0) q.push_back(rom[m_iaddr]);
      m_infl  = int'(e_rd && m_ph == 2);
      m_iaddr = m_next;
      m_prd   = int'(e_rd && m_ph == 1);
      m_paddr = m_next;
      if (e_rd) begin m_last = m_next; m_next++; end
      if (m_ph == 1 && m_next == FC_BASE) m_ph = 2;
      if (m_ph == 2) m_rdy = int'(m_rdy != 0 || q.size() == 2 || q.size() == FC_IN - m_popped);
      if (pop && m_popped == FC_IN) begin m_ph = 0; m_done = 1; m_rdy = 0; end
      if (idle && bus.start) begin
        m_ph = 1; m_next = 0; m_uf = 0; m_popped = 0; m_rdy = 0; s_cyc = cyc;
        t_en0 = -1; t_en1 = -1; t_rdy = -1; f_pops = 0; c0 = '0; c1 = '0;
        foreach (t_addr[i]) t_addr[i] = -1;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_done();
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (bus.done) return;
    end
    $display("FAIL done_timeout at cycle %0d", cyc);
    $fatal(1, "done never arrived");
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  initial begin
    logic [8:0] p0, p1;
    p0 = 9'b101101100;
    p1 = 9'b011011010;
    rstn = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 10'($urandom);
    for (int i = 0; i < CW; i++) begin
      rom[i]      = {9'($urandom), p0[8-i]};
      rom[CW + i] = {9'($urandom), p1[8-i]};
    end
    for (int n = 0; n < FC_IN; n++) rom[FC_BASE + n] = 10'(n);
    repeat (3) tick();
    rstn = 1'b1;
    repeat (3) tick();
    lit_sel = 1; mode = 1;
    pulse_start();
    wait_done();
    tick();
    lit_sel = 2; mode = 2;
    pulse_start();
    repeat (10) tick();
    pulse_start();
    repeat (28) tick();
    pulse_start();
    wait_done();
    tick();
    lit_sel = 3; mode = 0;
    pulse_start();
    repeat (17) tick();
    mode = 4;
    tick();
    mode = 1;
    wait_done();
    pulse_start();
    lit_sel = 4;
    wait_done();
    tick();
    lit_sel = 0; mode = 0;
    pulse_start();
    for (int i = 0; i < 100 && !bus.fc_ready; i++) tick();
    rstn = 1'b0;
    repeat (2) tick();
    rstn = 1'b1;
    repeat (5) tick();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 256; i++) rom[i] = 10'($urandom);
      mode = 3;
      pulse_start();
      for (int i = 0; i < 3000; i++) begin
        tick();
        if (bus.done) break;
        if (i == 2999) begin
          $display("FAIL random_done_timeout at cycle %0d", cyc);
          $fatal(1, "done never arrived");
        end
        bus.start = $urandom_range(0, 30) == 0;
      end
      bus.start = 1'b0;
      mode = 0;
      repeat ($urandom_range(1, 4)) tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule
